// File: rtl/imem_line_server.sv
// Instruction-memory line server: accepts one refill request and returns the 128-bit
// line after LATENCY cycles. The IMEM_LINE_ERR_EN macro enables out-of-range flagging.
//
// state  | meaning
// IDLE   | ready for a request; an accept latches the aligned address
// WAIT   | latency countdown; the counter reaches 0 on the last WAIT cycle
// RESP   | one-cycle resp_valid pulse; the line was captured on entry
module imem_line_server #(
   parameter int LINES   = 64,
   parameter int LATENCY = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [31:0]  req_addr,
   output logic         resp_valid,
   output logic [127:0] resp_line,
   output logic [31:0]  resp_addr,
   output logic         resp_err,
   input  logic         ld_en,
   input  logic [31:0]  ld_addr,
   input  logic [31:0]  ld_data,
   output logic         busy
);

   localparam int IW = $clog2(LINES);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [27:0]    addr_q, addr_d;
   logic [127:0]   line_q, line_d;
   logic [31:0]    raddr_q, raddr_d;
   logic           err_q, err_d;

   logic [31:0]    mem_q [LINES*4];

   logic [27:0]    rd_addr;
   logic [IW-1:0]  rd_idx;
   logic [127:0]   rd_line;
   logic           rd_oor;
   logic           ld_oor;
   logic           enter_resp;
   logic           unused_bits;

   // In IDLE the store is read with the incoming address so LATENCY=1 can capture on the accept edge.
   assign rd_addr = (state_q == S_IDLE) ? req_addr[31:4] : addr_q;
   assign rd_idx  = rd_addr[IW-1:0];
   assign rd_line = {mem_q[{rd_idx, 2'd3}], mem_q[{rd_idx, 2'd2}],
                     mem_q[{rd_idx, 2'd1}], mem_q[{rd_idx, 2'd0}]};

`ifdef IMEM_LINE_ERR_EN
   assign rd_oor = |rd_addr[27:IW];
   assign ld_oor = |ld_addr[31:IW+4];
`else
   assign rd_oor = 1'b0;
   assign ld_oor = 1'b0;
`endif

   assign unused_bits = ^{req_addr[3:0], ld_addr[1:0], ld_addr[31:IW+4]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      line_d     = line_q;
      raddr_d    = raddr_q;
      err_d      = err_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d = req_addr[31:4];
               if (LATENCY == 1) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (enter_resp) begin
         line_d  = rd_oor ? '0 : rd_line;
         raddr_d = {rd_addr, 4'b0000};
         err_d   = rd_oor;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         line_q  <= '0;
         raddr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
         raddr_q <= raddr_d;
         err_q   <= err_d;
      end
   end

   // Backing store is deliberately not reset so the loaded image survives rstn.
   always_ff @(posedge clk) begin
      if (ld_en && !ld_oor) begin
         mem_q[ld_addr[IW+3:2]] <= ld_data;
      end
   end

   assign resp_line = line_q;
   assign resp_addr = raddr_q;
   assign resp_err  = err_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_line_server.sv
// Directed bench for imem_line_server: vector table of line requests plus sequences for
// back-to-back requests, LATENCY=1, same-edge load, reset abort and load aliasing.
module tb_imem_line_server;

   localparam int LINES   = 64;
   localparam int LATENCY = 3;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         req_valid = 1'b0, req_valid1 = 1'b0;
   logic [31:0]  req_addr = '0, req_addr1 = '0;
   logic         req_ready, req_ready1;
   logic         resp_valid, resp_valid1;
   logic [127:0] resp_line, resp_line1;
   logic [31:0]  resp_addr, resp_addr1;
   logic         resp_err, resp_err1;
   logic         busy, busy1;
   logic         ld_en = 1'b0;
   logic [31:0]  ld_addr = '0, ld_data = '0;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   imem_line_server #(.LINES(LINES), .LATENCY(LATENCY)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .resp_valid(resp_valid), .resp_line(resp_line),
      .resp_addr(resp_addr), .resp_err(resp_err), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .busy(busy));

   imem_line_server #(.LINES(LINES), .LATENCY(1)) dut1 (
      .clk(clk), .rstn(rstn), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_addr(req_addr1), .resp_valid(resp_valid1), .resp_line(resp_line1),
      .resp_addr(resp_addr1), .resp_err(resp_err1), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .busy(busy1));

   typedef struct {
      logic [31:0]  addr;
      logic [127:0] line;
      logic [31:0]  raddr;
      logic         err;
   } vec_t;

   localparam logic [127:0] LINE0  = 128'hA0000003_A0000002_A0000001_A0000000;
   localparam logic [127:0] LINE1  = 128'hB0000003_B0000002_B0000001_B0000000;
   localparam logic [127:0] LINE2  = 128'hC0000003_C0000002_C0000001_C0000000;
   localparam logic [127:0] LINE4  = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] LINE63 = 128'hF0000003_F0000002_F0000001_F0000000;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic ld(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   // Issue one request; the pulse must be seen at the LATENCY-th falling edge after the accept edge.
   task automatic do_req(input logic [31:0] a, output logic [127:0] line,
                         output logic [31:0] raddr, output logic err);
      int  k;
      logic got;
      @(negedge clk);
      chk("ready_before_req", req_ready, 1'b1);
      req_valid = 1'b1; req_addr = a;
      @(posedge clk); #1;
      req_valid = 1'b0;
      k = 0; got = 1'b0;
      while (k < 20 && !got) begin
         @(negedge clk);
         k++;
         if (resp_valid) got = 1'b1;
      end
      chk("resp_seen", got, 1'b1);
      chk("latency", k, LATENCY);
      line = resp_line; raddr = resp_addr; err = resp_err;
      @(negedge clk);
      chk("pulse_one_cycle", resp_valid, 1'b0);
      chk("ready_after_resp", req_ready, 1'b1);
      chk("held_line", resp_line, line);
   endtask

   vec_t vecs[6];
   logic [127:0] l;
   logic [31:0]  ra;
   logic         e;
   int pulse[4];
   logic [127:0] pline[4];
   int acc[4];
   int na, np, nv;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h0000_0048, LINE4,  32'h0000_0040, 1'b0};
      vecs[1] = '{32'h0000_0040, LINE4,  32'h0000_0040, 1'b0};
      vecs[2] = '{32'h0000_0007, LINE0,  32'h0000_0000, 1'b0};
      vecs[3] = '{32'h0000_03FC, LINE63, 32'h0000_03F0, 1'b0};
`ifdef IMEM_LINE_ERR_EN
      vecs[4] = '{32'h0000_0400, 128'h0, 32'h0000_0400, 1'b1};
      vecs[5] = '{32'hFFFF_F04C, 128'h0, 32'hFFFF_F040, 1'b1};
`else
      vecs[4] = '{32'h0000_0400, LINE0, 32'h0000_0400, 1'b0};
      vecs[5] = '{32'hFFFF_F04C, LINE4, 32'hFFFF_F040, 1'b0};
`endif

      #12;
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_valid", resp_valid, 1'b0);
      chk("rst_line", resp_line, 128'h0);
      chk("rst_addr", resp_addr, 32'h0);
      chk("rst_err", resp_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk); rstn = 1'b1;

      for (int w = 0; w < 4; w++) begin
         ld(32'h40 + 32'(4*w), 32'h11111111 * (w + 1));
         ld(32'h00 + 32'(4*w), 32'hA0000000 + 32'(w));
         ld(32'h10 + 32'(4*w), 32'hB0000000 + 32'(w));
         ld(32'h20 + 32'(4*w), 32'hC0000000 + 32'(w));
         ld(32'h3F0 + 32'(4*w) + 32'd3, 32'hF0000000 + 32'(w));
      end
      ld(32'h30, 32'h0);

      for (int i = 0; i < 6; i++) begin
         do_req(vecs[i].addr, l, ra, e);
         chk($sformatf("vec%0d_line", i), l, vecs[i].line);
         chk($sformatf("vec%0d_addr", i), ra, vecs[i].raddr);
         chk($sformatf("vec%0d_err", i), e, vecs[i].err);
      end

      // req_valid held high: accepts 4 cycles apart, ready low for the three cycles between
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0; na = 0; np = 0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (resp_valid && np < 4) begin pulse[np] = c; pline[np] = resp_line; np++; end
         if (c >= 1 && c <= 3) chk($sformatf("b2b_ready_c%0d", c), req_ready, 1'b0);
         if (req_ready && req_valid && na < 4) begin acc[na] = c; na++; end
         @(posedge clk); #1;
         if (na == 1) req_addr = 32'h10;
         if (na == 2) req_valid = 1'b0;
      end
      chk("b2b_accepts", na, 2);
      chk("b2b_second_accept", acc[1], 4);
      chk("b2b_pulses", np, 2);
      chk("b2b_pulse0", pulse[0], 3);
      chk("b2b_pulse1", pulse[1], 7);
      chk("b2b_line0", pline[0], LINE0);
      chk("b2b_line1", pline[1], LINE1);

      // LATENCY=1 instance
      @(negedge clk);
      chk("lat1_idle_busy", busy1, 1'b0);
      req_valid1 = 1'b1; req_addr1 = 32'h20;
      @(posedge clk); #1;
      req_valid1 = 1'b0;
      @(negedge clk);
      chk("lat1_valid", resp_valid1, 1'b1);
      chk("lat1_busy", busy1, 1'b1);
      chk("lat1_line", resp_line1, LINE2);
      chk("lat1_addr", resp_addr1, 32'h20);
      @(negedge clk);
      chk("lat1_valid_drop", resp_valid1, 1'b0);
      chk("lat1_busy_drop", busy1, 1'b0);

      // Load on the RESP-entry edge (accept edge + LATENCY-1) must not be visible
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h30;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      ld_en = 1'b1; ld_addr = 32'h30; ld_data = 32'hDEADBEEF;
      @(posedge clk); #1;
      ld_en = 1'b0;
      @(negedge clk);
      chk("same_edge_valid", resp_valid, 1'b1);
      chk("same_edge_old", resp_line[31:0], 32'h0);
      do_req(32'h30, l, ra, e);
      chk("same_edge_new", l[31:0], 32'hDEADBEEF);

      // Reset during WAIT aborts the response; store survives
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h48;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", busy, 1'b1);
      rstn = 1'b0;
      #1;
      chk("rst_mid_ready", req_ready, 1'b1);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_line", resp_line, 128'h0);
      chk("rst_mid_addr", resp_addr, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      nv = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (resp_valid) nv++;
      end
      chk("rst_no_pulse", nv, 0);
      do_req(32'h48, l, ra, e);
      chk("rst_kept_store", l, LINE4);

      // Out-of-range load: aliases onto word 0 by default, dropped when flagged
      ld(32'h1000_0400, 32'h77777777);
`ifdef IMEM_LINE_ERR_EN
      do_req(32'h0, l, ra, e);
      chk("ld_oor_dropped", l[31:0], 32'hA0000000);
`else
      do_req(32'h0, l, ra, e);
      chk("ld_alias", l[31:0], 32'h77777777);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
